// File: rtl/sdram_rw_checker_if.sv
// sdram_rw_checker_if
//   Bundles the SDRAM controller user-port handshake and the status outputs
//   of sdram_rw_checker.
//   master : checker side (drives wr_en/wr_data/rd_en and the status outputs)
//   slave  : controller / LED side (drives init_done, ready/valid, rd_data)
//   Signals:
//     init_done  controller initialisation complete
//     wr_en, wr_data, wr_ready             write beat handshake
//     rd_en, rd_ready                      read request handshake
//     rd_valid, rd_data                    read response, in request order
//     test_done, error_flag, err_cnt       checker status
interface sdram_rw_checker_if #(
    parameter int unsigned DATA_W = 16
);
    logic              init_done;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_en;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              test_done;
    logic              error_flag;
    logic [15:0]       err_cnt;

    modport master (
        input  init_done, wr_ready, rd_ready, rd_valid, rd_data,
        output wr_en, wr_data, rd_en, test_done, error_flag, err_cnt
    );

    modport slave (
        output init_done, wr_ready, rd_ready, rd_valid, rd_data,
        input  wr_en, wr_data, rd_en, test_done, error_flag, err_cnt
    );
endinterface

// File: rtl/sdram_rw_checker.sv
// sdram_rw_checker
//   Writes an incrementing pattern through the SDRAM controller user port,
//   idles for GAP_CYCLES, reads the block back and compares every word.
//   Mismatching or spurious read responses set the sticky error_flag and
//   bump the saturating err_cnt one cycle after the offending rd_valid.
//   Ports:
//     clk_50m  system clock, rising edge
//     rst      synchronous active-high reset
//     bus      sdram_rw_checker_if.master (handshakes + status outputs)
//   Build option:
//     SDRAM_RW_LOOP_EN  when defined, DONE lasts one cycle and the test
//                       restarts with the pattern base advanced by one;
//                       otherwise a single pass ends in a held DONE.
module sdram_rw_checker #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned TEST_LEN   = 1024,
    parameter int unsigned START_VAL  = 1,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic                  clk_50m,
    input  logic                  rst,
    sdram_rw_checker_if.master    bus
);

    localparam int unsigned       CW    = 17;
    localparam logic [CW-1:0]     LEN   = CW'(TEST_LEN);
    localparam logic [DATA_W-1:0] START = DATA_W'(START_VAL);
    localparam logic [31:0]       GAP_LAST = 32'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_WRITE,
        S_GAP,
        S_READ,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]     req_cnt_q, req_cnt_d;
    logic [CW-1:0]     rsp_cnt_q, rsp_cnt_d;
    logic [31:0]       gap_cnt_q, gap_cnt_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [DATA_W-1:0] base_q, base_d;
    logic              error_flag_q, error_flag_d;
    logic [15:0]       err_cnt_q, err_cnt_d;

    logic              rd_en_c;
    logic              rsp_ok;
    logic [DATA_W-1:0] exp_data;
    logic              err_hit;

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_q      <= S_WAIT_INIT;
            wr_cnt_q     <= '0;
            req_cnt_q    <= '0;
            rsp_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            wr_data_q    <= START;
            base_q       <= '0;
            error_flag_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            req_cnt_q    <= req_cnt_d;
            rsp_cnt_q    <= rsp_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            wr_data_q    <= wr_data_d;
            base_q       <= base_d;
            error_flag_q <= error_flag_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        req_cnt_d    = req_cnt_q;
        rsp_cnt_d    = rsp_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        wr_data_d    = wr_data_q;
        base_d       = base_q;
        error_flag_d = error_flag_q;
        err_cnt_d    = err_cnt_q;

        rd_en_c  = (state_q == S_READ) && (req_cnt_q < LEN);
        // A response is only expected in READ until the block is complete;
        // anything else on rd_valid is spurious.
        rsp_ok   = (state_q == S_READ) && (rsp_cnt_q < LEN);
        exp_data = START + base_q + DATA_W'(rsp_cnt_q);
        err_hit  = bus.rd_valid && (!rsp_ok || (bus.rd_data != exp_data));

        unique case (state_q)
            S_WAIT_INIT: begin
                if (bus.init_done) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (bus.wr_ready) begin
                    wr_cnt_d  = wr_cnt_q + 1'b1;
                    wr_data_d = wr_data_q + 1'b1;
                    if (wr_cnt_q == LEN - 1'b1) begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = S_READ;
                else                       gap_cnt_d = gap_cnt_q + 1'b1;
            end
            S_READ: begin
                if (rd_en_c && bus.rd_ready) req_cnt_d = req_cnt_q + 1'b1;
                if (bus.rd_valid && rsp_ok) begin
                    rsp_cnt_d = rsp_cnt_q + 1'b1;
                    if (rsp_cnt_q == LEN - 1'b1) state_d = S_DONE;
                end
            end
            S_DONE: begin
`ifdef SDRAM_RW_LOOP_EN
                // Next pass starts at START_VAL + (pass + 1); error state persists.
                state_d   = S_WRITE;
                base_d    = base_q + 1'b1;
                wr_cnt_d  = '0;
                req_cnt_d = '0;
                rsp_cnt_d = '0;
                wr_data_d = START + base_q + 1'b1;
`endif
            end
            default: state_d = S_WAIT_INIT;
        endcase

        if (err_hit) begin
            error_flag_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    assign bus.wr_en      = (state_q == S_WRITE);
    assign bus.wr_data    = wr_data_q;
    assign bus.rd_en      = rd_en_c;
    assign bus.test_done  = (state_q == S_DONE);
    assign bus.error_flag = error_flag_q;
    assign bus.err_cnt    = err_cnt_q;

endmodule
